adc_sample_sequencer: RTL and testbench
=======================================

// Module: adc_sample_sequencer
// PURPOSE
//  Drives the modular ADC command stream at a fixed sample rate and collects responses.
//  Converts each 12-bit offset-binary result into a left-justified signed audio sample.
//  Sits between adc_qsys (command/response ports) and the FM modulator sample input.
//  Presents samples on a 1-deep valid/ready output and counts overruns and timeouts.
// PARAMETERS
//  CLK_DIV        1250  clocks per sample tick; legal range >=4
//  CHANNEL        1     ADC channel requested in every command (5 bits)
//  TIMEOUT_CYCLES 256   max clocks in WAIT before the transaction is aborted
//  OUT_W          16    output sample width; legal range >=12
// PORTS
//  clk             in   1      single clock (same as adc_qsys sys clock)
//  reset           in   1      synchronous, active-high
//  enable          in   1      1 = generate sample ticks
//  adc_cmd_valid   out  1      command valid to modular ADC
//  adc_cmd_channel out  5      = CHANNEL
//  adc_cmd_sop     out  1      = adc_cmd_valid (single-beat packet)
//  adc_cmd_eop     out  1      = adc_cmd_valid
//  adc_cmd_ready   in   1      ADC accepts command
//  adc_rsp_valid   in   1      response valid
//  adc_rsp_channel in   5      response channel
//  adc_rsp_data    in   12     conversion result, offset binary
//  sample_data     out  OUT_W  signed sample
//  sample_valid    out  1      sample held
//  sample_ready    in   1      downstream accepts
//  overrun_cnt     out  8      saturating: samples overwritten + ticks missed
//  timeout_err     out  1      sticky; set on WAIT timeout, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; tick counter=0; timeout counter=0.
//  Tick: counter runs 0..CLK_DIV-1 while enable=1; tick pulses 1 cycle at CLK_DIV-1, wraps to 0.
//   enable=0 -> counter held at 0, no ticks; in-flight transaction still completes.
//  FSM IDLE: on tick -> CMD (adc_cmd_valid=1 on the next cycle, registered).
//  FSM CMD: hold adc_cmd_valid=1 until adc_cmd_ready=1; that cycle is the handshake; next cycle
//   cmd_valid=0, state=WAIT, timeout counter=0.
//  FSM WAIT: adc_rsp_valid=1 with adc_rsp_channel==CHANNEL -> capture, state=IDLE.
//   Mismatched channel responses ignored. Counter reaches TIMEOUT_CYCLES-1 with no match
//   -> timeout_err=1, state=IDLE, no sample produced.
//  Tick while in CMD or WAIT: dropped, overrun_cnt++ (saturate at 255).
//  Conversion: sample_data <= {~d[11], d[10:0], (OUT_W-12)'b0}.
//   0x800->0x0000, 0xFFF->0x7FF0, 0x000->0x8000, 0x7FF->0xFFF0 (OUT_W=16).
//  Output reg: capture sets sample_valid=1 the cycle after the response beat (latency 1).
//   sample_valid&sample_ready -> sample_valid=0 next cycle unless new capture same cycle.
//   Capture while sample_valid=1 and sample_ready=0 -> overwrite data, overrun_cnt++.
//   Capture and sample_ready=1 same cycle -> old accepted, new loaded, no overrun.
//   Capture and dropped tick same cycle -> overrun_cnt +1 per event, saturating.
//  sample_data stable while sample_valid=1 and sample_ready=0, except on overwrite.
//  Reset mid-transaction: cmd_valid drops next edge; late ADC response ignored (IDLE).
// STRUCTURE
//  Package adc_seq_pkg: state enum {IDLE,CMD,WAIT}, ADC_DATA_W=12, ADC_CH_W=5,
//   function adc_to_signed(data) for the conversion.
//  Sub-module adc_tick_gen (CLK_DIV): clk, reset, enable -> tick.
//  Top: FSM, timeout counter, output register, overrun counter.
// TESTING
//  CLK_DIV=8, ADC ready immediate, rsp data 0xFFF 3 cycles later -> one sample 0x7FF0 per 8 clks.
//  Hold sample_ready=0 for 3 ticks, data 0x800,0x000,0x7FF -> sample_data=0xFFF0, overrun_cnt=2.
//  ADC never responds -> timeout_err=1 after TIMEOUT_CYCLES in WAIT; next tick issues new command.
//  adc_cmd_ready delayed 10 clks with CLK_DIV=8 -> cmd_valid held; overrun_cnt=1 for missed tick.
//  Response on channel 3 then channel 1 (0x000) -> only 0x8000 emitted.
//  Assert reset during WAIT, response arrives after -> all outputs 0, no sample emitted.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC sample sequencer.
// Holds the FSM state encoding, the ADC field widths and the offset-binary conversion.
package adc_seq_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    // Offset binary to two's complement is an MSB flip.
    function automatic logic [ADC_DATA_W-1:0] adc_to_signed(input logic [ADC_DATA_W-1:0] data);
        return {~data[ADC_DATA_W-1], data[ADC_DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Command/response bundle toward the modular ADC plus the downstream sample handshake.
// The master modport is the sequencer side; slave is the ADC/consumer side.
interface adc_sample_sequencer_if #(
    parameter int OUT_W = 16
);
    import adc_seq_pkg::*;

    logic                  adc_cmd_valid;
    logic [ADC_CH_W-1:0]   adc_cmd_channel;
    logic                  adc_cmd_sop;
    logic                  adc_cmd_eop;
    logic                  adc_cmd_ready;
    logic                  adc_rsp_valid;
    logic [ADC_CH_W-1:0]   adc_rsp_channel;
    logic [ADC_DATA_W-1:0] adc_rsp_data;
    logic [OUT_W-1:0]      sample_data;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output adc_cmd_valid, adc_cmd_channel, adc_cmd_sop, adc_cmd_eop,
        input  adc_cmd_ready,
        input  adc_rsp_valid, adc_rsp_channel, adc_rsp_data,
        output sample_data, sample_valid,
        input  sample_ready
    );

    modport slave (
        input  adc_cmd_valid, adc_cmd_channel, adc_cmd_sop, adc_cmd_eop,
        output adc_cmd_ready,
        output adc_rsp_valid, adc_rsp_channel, adc_rsp_data,
        input  sample_data, sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/adc_tick_gen.sv
// Sample-rate tick: counter runs 0..CLK_DIV-1 while enabled, tick is high for the cycle at CLK_DIV-1.
// Dropping enable parks the counter at 0 so the next enabled period starts a full interval.
module adc_tick_gen #(
    parameter int CLK_DIV = 1250
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Issues one ADC command per sample tick, waits for the matching response with a timeout,
// and presents converted samples on a 1-deep output register with overrun accounting.
//
// state | meaning
// IDLE  | no transaction; a tick launches a command
// CMD   | adc_cmd_valid held until adc_cmd_ready
// WAIT  | waiting for a response on CHANNEL, bounded by TIMEOUT_CYCLES
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int                  CLK_DIV        = 1250,
    parameter logic [ADC_CH_W-1:0] CHANNEL        = 5'd1,
    parameter int                  TIMEOUT_CYCLES = 256,
    parameter int                  OUT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    adc_sample_sequencer_if.master bus,
    output logic [7:0]             overrun_cnt,
    output logic                   timeout_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state, state_nxt;
    logic             tick;
    logic             rsp_match;
    logic             tmo_hit;
    logic             capture;
    logic             timeout_set;
    logic             tick_drop;
    logic             overwrite;
    logic [TMO_W-1:0] tmo_cnt;
    logic [OUT_W-1:0] sample_conv;
    logic [OUT_W-1:0] sample_q;
    logic             valid_q;
    logic [8:0]       ovr_sum;
    logic [7:0]       ovr_nxt;

    adc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign rsp_match   = bus.adc_rsp_valid && (bus.adc_rsp_channel == CHANNEL);
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign sample_conv = OUT_W'(adc_to_signed(bus.adc_rsp_data)) << (OUT_W - ADC_DATA_W);

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        timeout_set = 1'b0;
        tick_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_nxt = CMD;
            end
            CMD: begin
                tick_drop = tick;
                if (bus.adc_cmd_ready) state_nxt = WAIT;
            end
            WAIT: begin
                tick_drop = tick;
                if (rsp_match) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A capture and a dropped tick in the same cycle each count once.
    assign overwrite = capture && valid_q && !bus.sample_ready;
    assign ovr_sum   = {1'b0, overrun_cnt} + {8'd0, overwrite} + {8'd0, tick_drop};
    assign ovr_nxt   = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_cnt <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            overrun_cnt <= ovr_nxt;
            if (state == CMD) begin
                tmo_cnt <= '0;
            end else if (state == WAIT && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (capture) begin
                sample_q <= sample_conv;
                valid_q  <= 1'b1;
            end else if (bus.sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.adc_cmd_valid   = (state == CMD);
    assign bus.adc_cmd_sop     = bus.adc_cmd_valid;
    assign bus.adc_cmd_eop     = bus.adc_cmd_valid;
    assign bus.adc_cmd_channel = bus.adc_cmd_valid ? CHANNEL : '0;
    assign bus.sample_data     = sample_q;
    assign bus.sample_valid    = valid_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer: directed scenarios plus a randomized run,
// every cycle compared against a transaction-level reference model.
module tb_adc_sample_sequencer;
    import adc_seq_pkg::*;

    localparam int             CLK_DIV = 8;
    localparam int             TMO     = 32;
    localparam int             OUT_W   = 16;
    localparam logic [4:0]     CHAN    = 5'd1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] overrun_cnt;
    logic       timeout_err;

    int checks = 0;
    int passed = 0;

    adc_sample_sequencer_if #(.OUT_W(OUT_W)) bus ();

    adc_sample_sequencer #(
        .CLK_DIV        (CLK_DIV),
        .CHANNEL        (CHAN),
        .TIMEOUT_CYCLES (TMO),
        .OUT_W          (OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: busy/awaiting flags, enabled-cycle count for ticks, integer overrun tally.
    int               m_en_cycles;
    bit               m_cmd, m_await, m_full, m_tmo;
    int               m_age, m_ovr;
    logic [OUT_W-1:0] m_data;

    always @(posedge clk) begin : ref_model
        bit tick, got;
        int ev;
        if (reset) begin
            m_en_cycles = 0; m_cmd = 0; m_await = 0; m_full = 0; m_tmo = 0;
            m_age = 0; m_ovr = 0; m_data = '0;
        end else begin
            tick = enable && ((m_en_cycles % CLK_DIV) == CLK_DIV - 1);
            m_en_cycles = enable ? m_en_cycles + 1 : 0;
            got = m_await && bus.adc_rsp_valid && (bus.adc_rsp_channel == CHAN);
            ev = 0;
            if (tick && (m_cmd || m_await)) ev++;
            if (got && m_full && !bus.sample_ready) ev++;
            if (got) begin
                m_data = OUT_W'((int'(bus.adc_rsp_data) - 2048) * (1 << (OUT_W - 12)));
                m_full = 1;
            end else if (m_full && bus.sample_ready) begin
                m_full = 0;
            end
            if (m_cmd && bus.adc_cmd_ready) begin
                m_cmd = 0; m_await = 1; m_age = 0;
            end else if (m_await) begin
                if (got) m_await = 0;
                else if (m_age == TMO - 1) begin m_await = 0; m_tmo = 1; end
                else m_age++;
            end else if (tick) begin
                m_cmd = 1;
            end
            m_ovr = (m_ovr + ev > 255) ? 255 : m_ovr + ev;
        end
    end

    function automatic logic [33:0] dut_vec();
        return {bus.adc_cmd_valid, bus.adc_cmd_sop, bus.adc_cmd_eop, bus.adc_cmd_channel,
                bus.sample_valid, bus.sample_data, overrun_cnt, timeout_err};
    endfunction

    function automatic logic [33:0] exp_vec();
        return {m_cmd, m_cmd, m_cmd, (m_cmd ? CHAN : 5'd0), m_full, m_data, 8'(m_ovr), m_tmo};
    endfunction

    // ADC responder stimulus
    int  rdy_delay, rsp_delay, cur_rdy, rdy_wait, rsp_cnt, fix_data;
    bit  rnd_delays, no_rsp, wrong_first, cmd_seen, pending, wrong_pend;
    logic [11:0] data_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_adc();
        bus.adc_cmd_ready = 1'b0;
        bus.adc_rsp_valid = 1'b0;
        if (bus.adc_cmd_valid) begin
            if (!cmd_seen) begin
                cmd_seen = 1; rdy_wait = 0;
                cur_rdy = rnd_delays ? int'($urandom_range(0, 4)) : rdy_delay;
            end
            if (rdy_wait >= cur_rdy) begin
                bus.adc_cmd_ready = 1'b1;
                cmd_seen = 0;
                if (!no_rsp) begin
                    pending = 1;
                    rsp_cnt = rnd_delays ? int'($urandom_range(1, 6)) : rsp_delay;
                    wrong_pend = rnd_delays ? ($urandom_range(0, 3) == 0) : wrong_first;
                end
            end else begin
                rdy_wait++;
            end
        end else if (pending) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.adc_rsp_valid = 1'b1;
                if (wrong_pend) begin
                    bus.adc_rsp_channel = 5'(CHAN + 5'($urandom_range(1, 31)));
                    bus.adc_rsp_data = 12'($urandom_range(0, 4095));
                    wrong_pend = 0;
                    rsp_cnt = 1;
                end else begin
                    bus.adc_rsp_channel = CHAN;
                    if (data_q.size() > 0) bus.adc_rsp_data = data_q.pop_front();
                    else if (fix_data >= 0) bus.adc_rsp_data = 12'(fix_data);
                    else bus.adc_rsp_data = 12'($urandom_range(0, 4095));
                    pending = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        bus.sample_ready = 1'b0; bus.adc_cmd_ready = 1'b0; bus.adc_rsp_valid = 1'b0;
        bus.adc_rsp_channel = '0; bus.adc_rsp_data = '0;
        rdy_delay = 0; rsp_delay = 3; cur_rdy = 0; rdy_wait = 0; rsp_cnt = 0; fix_data = -1;
        rnd_delays = 0; no_rsp = 0; wrong_first = 0; cmd_seen = 0; pending = 0; wrong_pend = 0;
        data_q.delete();
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 34'd0) $display("FAIL reset_state: got %h want 0", dut_vec());
        else passed++;
    endtask

    task automatic test_basic();
        int nsamp = 0;
        do_reset();
        fix_data = 12'hFFF; bus.sample_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL basic_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (bus.sample_valid && bus.sample_ready) begin
                nsamp++;
                checks++;
                if (bus.sample_data !== 16'h7FF0) $display("FAIL basic_data: got %h want 7ff0", bus.sample_data);
                else passed++;
            end
            drive_adc();
        end
        checks++;
        if (nsamp != 5) $display("FAIL basic_count: got %0d want 5", nsamp);
        else passed++;
    endtask

    task automatic test_overrun();
        do_reset();
        data_q = '{12'h800, 12'h000, 12'h7FF};
        enable = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL ovr_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (i == 24) enable = 1'b0;
            drive_adc();
        end
        checks++;
        if ({bus.sample_valid, bus.sample_data, overrun_cnt} !== {1'b1, 16'hFFF0, 8'd2})
            $display("FAIL ovr_final: got v=%0b d=%h o=%0d want v=1 d=fff0 o=2",
                     bus.sample_valid, bus.sample_data, overrun_cnt);
        else passed++;
        bus.sample_ready = 1'b1;
        step();
        checks++;
        if (bus.sample_valid !== 1'b0 || dut_vec() !== exp_vec())
            $display("FAIL ovr_drain: got %h want %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_cmd_ready_delay();
        int nvalid = 0;
        do_reset();
        rdy_delay = 10; bus.sample_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rdly_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (bus.adc_cmd_valid) nvalid++;
            if (i == 20) enable = 1'b0;
            drive_adc();
        end
        checks++;
        if (nvalid != 11) $display("FAIL rdly_hold: got %0d want 11", nvalid);
        else passed++;
        checks++;
        if (overrun_cnt !== 8'd1) $display("FAIL rdly_ovr: got %0d want 1", overrun_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        int first_tmo = -1;
        int recmd = -1;
        do_reset();
        no_rsp = 1; bus.sample_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL tmo_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (timeout_err && first_tmo < 0) first_tmo = i;
            if (first_tmo > 0 && i > first_tmo && bus.adc_cmd_valid && recmd < 0) recmd = i;
            drive_adc();
        end
        checks++;
        if (first_tmo != 41) $display("FAIL tmo_when: got %0d want 41", first_tmo);
        else passed++;
        checks++;
        if (recmd != 48) $display("FAIL tmo_recmd: got %0d want 48", recmd);
        else passed++;
        checks++;
        if ({overrun_cnt, bus.sample_valid} !== {8'd4, 1'b0})
            $display("FAIL tmo_ovr: got o=%0d v=%0b want o=4 v=0", overrun_cnt, bus.sample_valid);
        else passed++;
    endtask

    task automatic test_channel();
        int nsamp = 0;
        logic [15:0] last = '0;
        do_reset();
        wrong_first = 1; fix_data = 12'h000; bus.sample_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL chan_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (bus.sample_valid && bus.sample_ready) begin nsamp++; last = bus.sample_data; end
            if (i == 8) enable = 1'b0;
            drive_adc();
        end
        checks++;
        if (nsamp != 1 || last !== 16'h8000) $display("FAIL chan_only: got n=%0d d=%h want n=1 d=8000", nsamp, last);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_delay = 6; bus.sample_ready = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rmid_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            if (i >= 11) begin
                checks++;
                if (dut_vec() !== 34'd0) $display("FAIL rmid_zero%0d: got %h want 0", i, dut_vec());
                else passed++;
            end
            if (i == 8) enable = 1'b0;
            reset = (i == 10);
            drive_adc();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        no_rsp = 1; enable = 1'b1;
        for (int i = 1; i <= 2700; i++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL sat_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            drive_adc();
        end
        checks++;
        if (overrun_cnt !== 8'd255) $display("FAIL sat_final: got %0d want 255", overrun_cnt);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        rnd_delays = 1;
        for (int i = 1; i <= 3000; i++) begin
            enable = ($urandom_range(0, 19) != 0);
            bus.sample_ready = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_c%0d: got %h want %h", i, dut_vec(), exp_vec());
            else passed++;
            drive_adc();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_cmd_ready_delay();
        test_timeout();
        test_channel();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
